cache_refill_controller: RTL and testbench

- Miss-handling and memory-side engine for the direct-mapped, write-through, no-write-allocate data cache.
- Watches CPU load/store requests against the tag unit's hit flag.
- On a read miss, stalls the CPU, fetches the whole 4-word block from main memory over a valid/ready handshake, writes each word into the cache data array, then pulses the tag/valid update.
- On a store, writes through to memory and updates the cached word on a hit.

---
 rtl/cache_refill_if.sv | 36 +++
 rtl/cache_refill_controller.sv | 139 +++++++++++++
 tb/tb_cache_refill_controller.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_if.sv
// CPU, memory and cache-array signal bundle for the refill controller.
interface cache_refill_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  hit;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  fill_we;
  logic [1:0]            fill_offset;
  logic [DATA_WIDTH-1:0] fill_data;
  logic                  tag_we;

  // Controller side
  modport master (
    input  cpu_addr, cpu_rd, cpu_wr, cpu_wdata, hit, mem_ready, mem_rdata,
    output stall, mem_req, mem_we, mem_addr, mem_wdata,
    output fill_we, fill_offset, fill_data, tag_we
  );

  // CPU / memory / tag-unit side
  modport slave (
    output cpu_addr, cpu_rd, cpu_wr, cpu_wdata, hit, mem_ready, mem_rdata,
    input  stall, mem_req, mem_we, mem_addr, mem_wdata,
    input  fill_we, fill_offset, fill_data, tag_we
  );
endinterface

// File: rtl/cache_refill_controller.sv
// Miss handling and write-through engine for a direct-mapped, 4-word-block data cache.
module cache_refill_controller #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  cache_refill_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_TAG   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                r_state;
  logic [1:0]            r_cnt;
  logic [ADDR_WIDTH-1:2] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_hit;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_tag_we;

  logic w_rd_miss;
  logic w_fill_rd;
  logic w_fill_wr;
  logic w_unused;

  assign w_rd_miss = bus.cpu_rd & ~bus.hit;
  assign w_unused  = ^bus.cpu_addr[1:0];

  // Controller state, latched request and registered memory/tag outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_hit       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_tag_we    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_wr) begin
            r_state     <= S_WRITE;
            r_addr      <= bus.cpu_addr[ADDR_WIDTH-1:2];
            r_data      <= bus.cpu_wdata;
            r_hit       <= bus.hit;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            r_mem_wdata <= bus.cpu_wdata;
          end else if (w_rd_miss) begin
            r_state    <= S_FILL;
            r_cnt      <= '0;
            r_addr     <= bus.cpu_addr[ADDR_WIDTH-1:2];
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {bus.cpu_addr[ADDR_WIDTH-1:4], 4'b0000};
          end
        end
        S_FILL: begin
          // Address advances only on an accepted word, so it holds through wait states
          if (bus.mem_ready) begin
            r_cnt      <= r_cnt + 2'd1;
            r_mem_addr <= {r_addr[ADDR_WIDTH-1:4], r_cnt + 2'd1, 2'b00};
            if (r_cnt == 2'd3) begin
              r_state   <= S_TAG;
              r_mem_req <= 1'b0;
              r_tag_we  <= 1'b1;
            end
          end
        end
        S_TAG: begin
          r_tag_we <= 1'b0;
          r_state  <= S_IDLE;
        end
        S_WRITE: begin
          if (bus.mem_ready) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        S_DONE: begin
          // One unstalled cycle lets the CPU retire the store before new requests are seen
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fill_rd = (r_state == S_FILL) & bus.mem_ready;
  assign w_fill_wr = (r_state == S_WRITE) & bus.mem_ready & r_hit;

  // Cache data-array write port: refill words, or the write-through word on a store hit
  always_comb begin
    bus.fill_we     = w_fill_rd | w_fill_wr;
    bus.fill_offset = 2'b00;
    bus.fill_data   = '0;
    if (w_fill_rd) begin
      bus.fill_offset = r_cnt;
      bus.fill_data   = bus.mem_rdata;
    end else if (w_fill_wr) begin
      bus.fill_offset = r_addr[3:2];
      bus.fill_data   = r_data;
    end
  end

  // CPU stall: pending miss/store detected in IDLE, or any busy state
  always_comb begin
    bus.stall = 1'b0;
    if (!reset) begin
      case (r_state)
        S_IDLE:                  bus.stall = bus.cpu_wr | w_rd_miss;
        S_FILL, S_TAG, S_WRITE:  bus.stall = 1'b1;
        default:                 bus.stall = 1'b0;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.tag_we    = r_tag_we;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller with a memory responder and a tag/data-array model.
module tb_cache_refill_controller;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int K_RD = 0, K_WR = 1, K_FILL = 2, K_TAG = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_refill_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  cache_refill_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  typedef struct { int kind; logic [31:0] a; logic [31:0] d; } ev_t;
  ev_t sb[$];
  int tests = 0, fails = 0;

  // Environment: 8-line tag unit and data array, reacting to the controller's write strobes
  logic        tu_valid [8] = '{default: 1'b0};
  logic [24:0] tu_tag   [8] = '{default: '0};
  logic [31:0] cdata    [32] = '{default: '0};
  assign bus.hit = tu_valid[bus.cpu_addr[6:4]] && (tu_tag[bus.cpu_addr[6:4]] == bus.cpu_addr[31:7]);

  always @(posedge clk) begin
    if (!reset && bus.tag_we) begin
      tu_valid[bus.cpu_addr[6:4]] <= 1'b1;
      tu_tag[bus.cpu_addr[6:4]]   <= bus.cpu_addr[31:7];
    end
    if (!reset && bus.fill_we) cdata[{bus.cpu_addr[6:4], bus.fill_offset}] <= bus.fill_data;
  end

  // Reference model: memory contents and which blocks are cached
  logic [31:0] phys    [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  bit          ref_valid [8] = '{default: 1'b0};
  logic [24:0] ref_tag   [8] = '{default: '0};

  function automatic logic [31:0] init_word(logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction
  function automatic logic [31:0] phys_rd(logic [31:0] a);
    return phys.exists(a) ? phys[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction
  function automatic void push(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    e.kind = k; e.a = a; e.d = d;
    sb.push_back(e);
  endfunction

  // Memory responder: ready pattern per mode, counts wait cycles on live requests
  int mode = 0, nwait = 0, wc = 0, waits = 0;
  always begin
    @(posedge clk);
    if (!reset && bus.mem_req && bus.mem_we && bus.mem_ready) phys[bus.mem_addr] = bus.mem_wdata;
    #1;
    if (reset) begin
      bus.mem_ready = 1'b0; wc = 0;
    end else if (!bus.mem_req) begin
      wc = 0;
      bus.mem_ready = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.mem_rdata = $urandom;
    end else begin
      case (mode)
        1: bus.mem_ready = 1'b1;
        2: if (wc >= nwait) begin bus.mem_ready = 1'b1; wc = 0; end
           else begin bus.mem_ready = 1'b0; wc++; end
        default: bus.mem_ready = ($urandom_range(0, 9) < 6);
      endcase
      if (!bus.mem_ready) waits++;
      bus.mem_rdata = bus.mem_ready ? phys_rd(bus.mem_addr) : $urandom;
    end
  end

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_ev(int k, logic [31:0] a, logic [31:0] d);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL sb_event: got kind=%0d a=%h d=%h, required no event (t=%0t)", k, a, d, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.a !== a || e.d !== d) begin
        fails++;
        $display("FAIL sb_event: got kind=%0d a=%h d=%h, required kind=%0d a=%h d=%h (t=%0t)",
                 k, a, d, e.kind, e.a, e.d, $time);
      end
    end
  endtask

  // Monitor: every observed memory transfer, array write and tag write must match the queue head
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mem_req && bus.mem_ready)
        check_ev(bus.mem_we ? K_WR : K_RD, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 32'h0);
      if (bus.fill_we) check_ev(K_FILL, 32'(bus.fill_offset), bus.fill_data);
      if (bus.tag_we)  check_ev(K_TAG, 32'h0, 32'h0);
    end
  end

  function automatic logic outs_any();
    return |{bus.stall, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
             bus.fill_we, bus.fill_offset, bus.fill_data, bus.tag_we};
  endfunction

  // Push the expected traffic for a miss refill of the block holding a
  task automatic push_refill(logic [31:0] a);
    logic [31:0] blk, wk;
    blk = {a[31:4], 4'b0000};
    for (int k = 0; k < 4; k++) begin
      wk = blk + 32'(4 * k);
      push(K_RD, wk, 32'h0);
      push(K_FILL, 32'(k), ref_rd(wk));
    end
    push(K_TAG, 32'h0, 32'h0);
  endtask

  // One CPU operation, entered and left at posedge+1
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       output int cyc);
    logic [2:0]  idx;
    logic [31:0] wa;
    bit          rhit;
    int          base, w0;
    idx  = a[6:4];
    wa   = {a[31:2], 2'b00};
    rhit = ref_valid[idx] && (ref_tag[idx] == a[31:7]);
    base = 0;
    if (wr) begin
      push(K_WR, wa, d);
      if (rhit) push(K_FILL, 32'(a[3:2]), d);
      ref_mem[wa] = d;
      base = 2;
    end else if (rd && !rhit) begin
      push_refill(a);
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = a[31:7];
      base = 6;
    end
    w0 = waits;
    bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    cyc = 0;
    while (bus.stall && cyc < 300) begin
      cyc++;
      @(negedge clk);
    end
    check("stall_cycles", 64'(cyc), 64'(base + (waits - w0)));
    if (rd && !wr) begin
      check("hit_after", 64'(bus.hit), 64'(1));
      check("hit_data", 64'(cdata[{a[6:4], a[3:2]}]), 64'(ref_rd(wa)));
    end
    @(posedge clk); #1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0;
    @(posedge clk); #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nf, r;
    logic [31:0] a;
    reset = 1'b1;
    bus.cpu_rd = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      phys[32'h120 + 32'(4 * k)]    = 32'hA0 + 32'(k);
      ref_mem[32'h120 + 32'(4 * k)] = 32'hA0 + 32'(k);
    end
    @(negedge clk); @(negedge clk);
    check("reset_outs", 64'(outs_any()), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Read miss, ready always high
    mode = 1;
    do_op(1'b1, 1'b0, 32'h0000_0124, 32'h0, cyc);
    check("t1_stall6", 64'(cyc), 64'(6));
    // Read miss, two wait states before every word
    mode = 2; nwait = 2;
    do_op(1'b1, 1'b0, 32'h0000_02A8, 32'h0, cyc);
    check("t2_stall14", 64'(cyc), 64'(14));
    // Store hit with delayed ready, then read it back
    mode = 1;
    do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, cyc);
    mode = 2; nwait = 2;
    do_op(1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, cyc);
    check("t3_stall4", 64'(cyc), 64'(4));
    mode = 1;
    do_op(1'b1, 1'b0, 32'h0000_0040, 32'h0, cyc);
    check("t3_readhit", 64'(cyc), 64'(0));
    // Store miss (no allocate), then refill sees the written word
    do_op(1'b0, 1'b1, 32'h0000_0088, 32'h1234_5678, cyc);
    check("t4_stall2", 64'(cyc), 64'(2));
    do_op(1'b1, 1'b0, 32'h0000_0088, 32'h0, cyc);
    // Simultaneous load and store on a miss takes the store path
    do_op(1'b1, 1'b1, 32'h0000_0300, 32'h0BAD_F00D, cyc);
    check("t5_stall2", 64'(cyc), 64'(2));

    // Reset after two refill words
    a = 32'h0000_01A4;
    push_refill(a);
    bus.cpu_rd = 1'b1; bus.cpu_addr = a;
    nf = 0; cyc = 0;
    while (nf < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (bus.fill_we) nf++;
    end
    check("t6_two_fills", 64'(nf), 64'(2));
    #1 reset = 1'b1;
    #1 check("t6_rst_outs", 64'(outs_any()), 64'(0));
    sb.delete();
    bus.cpu_rd = 1'b0;
    @(negedge clk);
    check("t6_rst_hold", 64'(outs_any()), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;
    check("t6_no_tag", 64'(bus.hit), 64'(0));
    do_op(1'b1, 1'b0, a, 32'h0, cyc);
    check("t6_refill6", 64'(cyc), 64'(6));

    // Random traffic with random memory wait states
    mode = 0;
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 9));
      do_op(r < 7, r >= 6, 32'($urandom_range(0, 1023)), $urandom, cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
